// File: rtl/fsm_antifurto_param.sv
// Parametrised car anti-theft controller.
// Watches N door inputs and the ignition switch, runs its own seconds countdown
// from a 1 Hz enable, and drives the status LED and siren directly.
// The delay table (rearm / driver entry / passenger entry / siren duration)
// can only be rewritten while the ignition is on, so it cannot be changed by
// someone who has not started the car.
module fsm_antifurto_param #(
    parameter int N_DOORS   = 4,
    parameter int TW        = 4,
    parameter int T_ARM_DEF = 6,
    parameter int T_DRV_DEF = 8,
    parameter int T_PAS_DEF = 15,
    parameter int T_ALM_DEF = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ignition,
    input  logic [N_DOORS-1:0] doors,
    input  logic               one_hz_enable,
    input  logic               reprogram,
    input  logic [1:0]         prog_sel,
    input  logic [TW-1:0]      prog_val,
    output logic               status,
    output logic               enable_siren,
    output logic [2:0]         estado,
    output logic [TW-1:0]      time_left,
    output logic [N_DOORS-1:0] trig_door
);

    typedef enum logic [2:0] {
        ST_ARMED     = 3'd0,
        ST_TRIGGERED = 3'd1,
        ST_ALARM     = 3'd2,
        ST_IGN_ON    = 3'd3,
        ST_IGN_OFF   = 3'd4,
        ST_DRV_OPEN  = 3'd5,
        ST_REARM     = 3'd6
    } state_t;

    localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};

    state_t               state_r;
    logic [TW-1:0]        timer_r;
    logic                 status_r;
    logic                 siren_r;
    logic [N_DOORS-1:0]   trig_r;

    logic [TW-1:0]        t_arm_r;
    logic [TW-1:0]        t_drv_r;
    logic [TW-1:0]        t_pas_r;
    logic [TW-1:0]        t_alm_r;

    logic                 expire_s;
    logic [TW-1:0]        timer_dec_s;
    logic [TW-1:0]        prog_eff_s;
    logic [N_DOORS-1:0]   low_door_s;
    logic                 any_door_s;
    logic                 prog_ok_s;

    // Timer helpers, lowest open door and sanitised program value.
    always_comb begin
        expire_s    = 1'b0;
        timer_dec_s = timer_r;
        prog_eff_s  = prog_val;
        if (one_hz_enable && (timer_r == TIMER_ONE)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
        if (one_hz_enable && (timer_r != TIMER_ZERO)) begin
            timer_dec_s = timer_r - TIMER_ONE;
        end else begin
            timer_dec_s = timer_r;
        end
        // A zero delay would never expire, so it is stored as one second.
        if (prog_val == TIMER_ZERO) begin
            prog_eff_s = TIMER_ONE;
        end else begin
            prog_eff_s = prog_val;
        end
        // Two's-complement trick isolates the lowest set bit.
        low_door_s = doors & (~doors + {{(N_DOORS-1){1'b0}}, 1'b1});
        any_door_s = |doors;
        prog_ok_s  = reprogram && (state_r == ST_IGN_ON);
    end

    // Delay table: writable only with the ignition on; new values apply at the next load.
    always_ff @(posedge clock) begin
        if (reset) begin
            t_arm_r <= TW'(T_ARM_DEF);
            t_drv_r <= TW'(T_DRV_DEF);
            t_pas_r <= TW'(T_PAS_DEF);
            t_alm_r <= TW'(T_ALM_DEF);
        end else if (prog_ok_s) begin
            case (prog_sel)
                2'd0:    t_arm_r <= prog_eff_s;
                2'd1:    t_drv_r <= prog_eff_s;
                2'd2:    t_pas_r <= prog_eff_s;
                2'd3:    t_alm_r <= prog_eff_s;
                default: t_arm_r <= t_arm_r;
            endcase
        end else begin
            t_arm_r <= t_arm_r;
        end
    end

    // Main FSM: state, countdown, LED, siren and trigger latch all registered together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_ARMED;
            timer_r  <= TIMER_ZERO;
            status_r <= 1'b0;
            siren_r  <= 1'b0;
            trig_r   <= {N_DOORS{1'b0}};
        end else begin
            case (state_r)
                ST_ARMED: begin
                    siren_r <= 1'b0;
                    if (ignition) begin
                        state_r  <= ST_IGN_ON;
                        status_r <= 1'b0;
                    end else if (doors[0]) begin
                        // Driver door takes priority over any passenger door.
                        state_r  <= ST_TRIGGERED;
                        timer_r  <= t_drv_r;
                        status_r <= 1'b1;
                        trig_r   <= {{(N_DOORS-1){1'b0}}, 1'b1};
                    end else if (any_door_s) begin
                        state_r  <= ST_TRIGGERED;
                        timer_r  <= t_pas_r;
                        status_r <= 1'b1;
                        trig_r   <= low_door_s;
                    end else if (one_hz_enable) begin
                        status_r <= ~status_r;
                    end else begin
                        status_r <= status_r;
                    end
                end
                ST_TRIGGERED: begin
                    timer_r <= timer_dec_s;
                    siren_r <= 1'b0;
                    if (ignition) begin
                        state_r  <= ST_IGN_ON;
                        status_r <= 1'b0;
                    end else if (expire_s) begin
                        state_r  <= ST_ALARM;
                        timer_r  <= t_alm_r;
                        status_r <= 1'b1;
                        siren_r  <= 1'b1;
                    end else begin
                        status_r <= 1'b1;
                    end
                end
                ST_ALARM: begin
                    timer_r <= timer_dec_s;
                    if (ignition) begin
                        state_r  <= ST_IGN_ON;
                        status_r <= 1'b0;
                        siren_r  <= 1'b0;
                    end else if (expire_s) begin
                        state_r  <= ST_ARMED;
                        status_r <= 1'b0;
                        siren_r  <= 1'b0;
                    end else begin
                        status_r <= 1'b1;
                        siren_r  <= 1'b1;
                    end
                end
                ST_IGN_ON: begin
                    status_r <= 1'b0;
                    siren_r  <= 1'b0;
                    if (!ignition) begin
                        state_r <= ST_IGN_OFF;
                    end else begin
                        state_r <= ST_IGN_ON;
                    end
                end
                ST_IGN_OFF: begin
                    status_r <= 1'b0;
                    siren_r  <= 1'b0;
                    if (ignition) begin
                        state_r <= ST_IGN_ON;
                    end else if (doors[0]) begin
                        state_r <= ST_DRV_OPEN;
                    end else begin
                        state_r <= ST_IGN_OFF;
                    end
                end
                ST_DRV_OPEN: begin
                    status_r <= 1'b0;
                    siren_r  <= 1'b0;
                    if (ignition) begin
                        state_r <= ST_IGN_ON;
                    end else if (!doors[0]) begin
                        state_r <= ST_REARM;
                        timer_r <= t_arm_r;
                    end else begin
                        state_r <= ST_DRV_OPEN;
                    end
                end
                ST_REARM: begin
                    status_r <= 1'b0;
                    siren_r  <= 1'b0;
                    timer_r  <= timer_dec_s;
                    if (ignition) begin
                        state_r <= ST_IGN_ON;
                    end else if (any_door_s) begin
                        // Any door activity restarts the rearm countdown.
                        timer_r <= t_arm_r;
                    end else if (expire_s) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_REARM;
                    end
                end
                default: begin
                    state_r  <= ST_ARMED;
                    status_r <= 1'b0;
                    siren_r  <= 1'b0;
                end
            endcase
        end
    end

    assign status       = status_r;
    assign enable_siren = siren_r;
    assign estado       = state_r;
    assign time_left    = timer_r;
    assign trig_door    = trig_r;

endmodule

// File: tb/tb_fsm_antifurto_param.sv
// Directed testbench for fsm_antifurto_param with default parameters.
module tb_fsm_antifurto_param;

    logic       clock;
    logic       reset;
    logic       ignition;
    logic [3:0] doors;
    logic       one_hz_enable;
    logic       reprogram;
    logic [1:0] prog_sel;
    logic [3:0] prog_val;
    logic       status;
    logic       enable_siren;
    logic [2:0] estado;
    logic [3:0] time_left;
    logic [3:0] trig_door;

    int n_cmp = 0;
    int n_err = 0;

    fsm_antifurto_param dut (
        .clock         (clock),
        .reset         (reset),
        .ignition      (ignition),
        .doors         (doors),
        .one_hz_enable (one_hz_enable),
        .reprogram     (reprogram),
        .prog_sel      (prog_sel),
        .prog_val      (prog_val),
        .status        (status),
        .enable_siren  (enable_siren),
        .estado        (estado),
        .time_left     (time_left),
        .trig_door     (trig_door)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One 1 Hz pulse followed by a few idle clocks.
    task automatic tick();
        one_hz_enable = 1'b1;
        step();
        one_hz_enable = 1'b0;
        repeat (3) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // From IGN_ON: ignition off, driver door open and close -> REARM.
    task automatic go_rearm();
        ignition = 1'b0; step();
        doors = 4'b0001; step();
        doors = 4'b0000; step();
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        reset = 1'b0;
        n_cmp++; if (estado !== 3'd0) begin n_err++; $display("FAIL rst_estado: got %0d want 0", estado); end
        n_cmp++; if (time_left !== 4'd0) begin n_err++; $display("FAIL rst_time: got %0d want 0", time_left); end
        n_cmp++; if (status !== 1'b0 || enable_siren !== 1'b0) begin n_err++; $display("FAIL rst_outs: got st=%b sir=%b want 0 0", status, enable_siren); end
        n_cmp++; if (trig_door !== 4'b0000) begin n_err++; $display("FAIL rst_trig: got %b want 0000", trig_door); end
    endtask

    task automatic test_driver_alarm();
        doors = 4'b0001; step(); doors = 4'b0000;
        n_cmp++; if (estado !== 3'd1 || time_left !== 4'd8 || status !== 1'b1) begin n_err++; $display("FAIL drv_trig: got st=%0d t=%0d led=%b want 1 8 1", estado, time_left, status); end
        n_cmp++; if (trig_door !== 4'b0001) begin n_err++; $display("FAIL drv_trigdoor: got %b want 0001", trig_door); end
        ticks(7);
        n_cmp++; if (estado !== 3'd1 || time_left !== 4'd1) begin n_err++; $display("FAIL drv_count: got st=%0d t=%0d want 1 1", estado, time_left); end
        tick();
        n_cmp++; if (estado !== 3'd2 || enable_siren !== 1'b1 || time_left !== 4'd10) begin n_err++; $display("FAIL alarm_entry: got st=%0d sir=%b t=%0d want 2 1 10", estado, enable_siren, time_left); end
        doors = 4'b1111; ticks(9); doors = 4'b0000;
        n_cmp++; if (estado !== 3'd2 || time_left !== 4'd1 || enable_siren !== 1'b1) begin n_err++; $display("FAIL alarm_count: got st=%0d t=%0d sir=%b want 2 1 1", estado, time_left, enable_siren); end
        tick();
        n_cmp++; if (estado !== 3'd0 || enable_siren !== 1'b0 || status !== 1'b0 || time_left !== 4'd0) begin n_err++; $display("FAIL alarm_exit: got st=%0d sir=%b led=%b t=%0d want 0 0 0 0", estado, enable_siren, status, time_left); end
    endtask

    task automatic test_passenger_ignition();
        doors = 4'b0110; step(); doors = 4'b0000;
        n_cmp++; if (estado !== 3'd1 || trig_door !== 4'b0010 || time_left !== 4'd15) begin n_err++; $display("FAIL pas_trig: got st=%0d door=%b t=%0d want 1 0010 15", estado, trig_door, time_left); end
        ticks(3);
        n_cmp++; if (time_left !== 4'd12) begin n_err++; $display("FAIL pas_count: got %0d want 12", time_left); end
        ignition = 1'b1; step();
        n_cmp++; if (estado !== 3'd3 || status !== 1'b0 || enable_siren !== 1'b0) begin n_err++; $display("FAIL ign_on: got st=%0d led=%b sir=%b want 3 0 0", estado, status, enable_siren); end
    endtask

    task automatic test_reprogram();
        reprogram = 1'b1; prog_sel = 2'd1; prog_val = 4'd3; step(); reprogram = 1'b0;
        ignition = 1'b0; step();
        n_cmp++; if (estado !== 3'd4) begin n_err++; $display("FAIL ign_off: got %0d want 4", estado); end
        doors = 4'b0001; step();
        n_cmp++; if (estado !== 3'd5) begin n_err++; $display("FAIL drv_open: got %0d want 5", estado); end
        doors = 4'b0000; step();
        n_cmp++; if (estado !== 3'd6 || time_left !== 4'd6) begin n_err++; $display("FAIL rearm_entry: got st=%0d t=%0d want 6 6", estado, time_left); end
        ticks(5);
        n_cmp++; if (estado !== 3'd6 || time_left !== 4'd1) begin n_err++; $display("FAIL rearm_count: got st=%0d t=%0d want 6 1", estado, time_left); end
        tick();
        n_cmp++; if (estado !== 3'd0 || time_left !== 4'd0) begin n_err++; $display("FAIL rearm_exit: got st=%0d t=%0d want 0 0", estado, time_left); end
        reprogram = 1'b1; prog_sel = 2'd1; prog_val = 4'd9; step(); reprogram = 1'b0;
        doors = 4'b0001; step(); doors = 4'b0000;
        n_cmp++; if (estado !== 3'd1 || time_left !== 4'd3) begin n_err++; $display("FAIL prog_drv: got st=%0d t=%0d want 1 3", estado, time_left); end
        ignition = 1'b1; step();
    endtask

    task automatic test_rearm_restart();
        go_rearm();
        ticks(4);
        n_cmp++; if (estado !== 3'd6 || time_left !== 4'd2) begin n_err++; $display("FAIL rr_pre: got st=%0d t=%0d want 6 2", estado, time_left); end
        doors = 4'b0100; step(); doors = 4'b0000; step();
        n_cmp++; if (estado !== 3'd6 || time_left !== 4'd6) begin n_err++; $display("FAIL rr_reload: got st=%0d t=%0d want 6 6", estado, time_left); end
        ticks(5);
        ignition = 1'b1; one_hz_enable = 1'b1; step(); one_hz_enable = 1'b0;
        n_cmp++; if (estado !== 3'd3) begin n_err++; $display("FAIL rr_ign_wins: got %0d want 3", estado); end
    endtask

    task automatic test_reset_in_alarm();
        go_rearm(); ticks(6);
        doors = 4'b0001; step(); doors = 4'b0000;
        ticks(3);
        n_cmp++; if (estado !== 3'd2 || time_left !== 4'd10) begin n_err++; $display("FAIL ra_alarm: got st=%0d t=%0d want 2 10", estado, time_left); end
        ticks(2);
        reset = 1'b1; step(); reset = 1'b0;
        n_cmp++; if (estado !== 3'd0 || enable_siren !== 1'b0 || time_left !== 4'd0 || status !== 1'b0) begin n_err++; $display("FAIL ra_reset: got st=%0d sir=%b t=%0d led=%b want 0 0 0 0", estado, enable_siren, time_left, status); end
        doors = 4'b0001; step(); doors = 4'b0000;
        n_cmp++; if (time_left !== 4'd8) begin n_err++; $display("FAIL ra_def_drv: got %0d want 8", time_left); end
        ticks(8);
        n_cmp++; if (estado !== 3'd2 || time_left !== 4'd10) begin n_err++; $display("FAIL ra_def_alm: got st=%0d t=%0d want 2 10", estado, time_left); end
        ignition = 1'b1; step();
        go_rearm();
        n_cmp++; if (time_left !== 4'd6) begin n_err++; $display("FAIL ra_def_arm: got %0d want 6", time_left); end
        ticks(6);
        doors = 4'b1000; step(); doors = 4'b0000;
        n_cmp++; if (time_left !== 4'd15 || trig_door !== 4'b1000) begin n_err++; $display("FAIL ra_def_pas: got t=%0d door=%b want 15 1000", time_left, trig_door); end
        ignition = 1'b1; step();
    endtask

    task automatic test_blink_short_alarm();
        logic [3:0] exp_blink;
        exp_blink = 4'b0101;
        reprogram = 1'b1; prog_sel = 2'd3; prog_val = 4'd0; step(); reprogram = 1'b0;
        go_rearm(); ticks(6);
        n_cmp++; if (estado !== 3'd0 || status !== 1'b0) begin n_err++; $display("FAIL bl_entry: got st=%0d led=%b want 0 0", estado, status); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (status !== exp_blink[i]) begin n_err++; $display("FAIL bl_led%0d: got %b want %b", i, status, exp_blink[i]); end
        end
        doors = 4'b0001; step(); doors = 4'b0000;
        ticks(8);
        n_cmp++; if (estado !== 3'd2 || time_left !== 4'd1 || enable_siren !== 1'b1) begin n_err++; $display("FAIL sa_entry: got st=%0d t=%0d sir=%b want 2 1 1", estado, time_left, enable_siren); end
        tick();
        n_cmp++; if (estado !== 3'd0 || enable_siren !== 1'b0) begin n_err++; $display("FAIL sa_exit: got st=%0d sir=%b want 0 0", estado, enable_siren); end
    endtask

    initial begin
        reset = 1'b0; ignition = 1'b0; doors = 4'b0000; one_hz_enable = 1'b0;
        reprogram = 1'b0; prog_sel = 2'd0; prog_val = 4'd0;
        test_reset();
        test_driver_alarm();
        test_passenger_ignition();
        test_reprogram();
        test_rearm_restart();
        test_reset_in_alarm();
        test_blink_short_alarm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
